// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: ALU op codes, opcode constants and the decoded-beat payload.
package rv32i_pkg;

  localparam int unsigned ILEN   = 32;
  localparam int unsigned XLEN_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_SLL    = 4'b0010,
    ALU_SLT    = 4'b0011,
    ALU_SLTU   = 4'b0100,
    ALU_XOR    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_OR     = 4'b1000,
    ALU_AND    = 4'b1001,
    ALU_PASS_B = 4'b1111
  } alu_op_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    alu_op_e            alu_op;
    logic               alu_src_a;
    logic               alu_src_b;
    logic [XLEN_W-1:0]  imm;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rd;
    logic [2:0]         funct3;
    logic               reg_we;
    logic               mem_re;
    logic               mem_we;
    logic               branch;
    logic               jump;
    logic               illegal;
  } decode_t;

  // alt is instr[30]; it only turns ADD into SUB for register-register ops.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt,
                                              input logic is_reg);
    alu_op_e op;
    case (funct3)
      3'd0:    op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic decode_t kill_strobes(input decode_t d);
    decode_t r;
    r        = d;
    r.reg_we = 1'b0;
    r.mem_re = 1'b0;
    r.mem_we = 1'b0;
    r.branch = 1'b0;
    r.jump   = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: selects the I/S/B/U/J format from the opcode.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [ILEN-1:0]   instr_i,
  output logic [XLEN_W-1:0] imm_o
);

  logic sign;
  assign sign = instr_i[31];

  always_comb begin
    imm_o = '0;
    case (instr_i[6:0])
      OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM:
        imm_o = {{20{sign}}, instr_i[31:20]};
      OPC_STORE:
        imm_o = {{20{sign}}, instr_i[31:25], instr_i[11:7]};
      OPC_BRANCH:
        imm_o = {{20{sign}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_o = {instr_i[31:12], 12'h000};
      OPC_JAL:
        imm_o = {{12{sign}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default:
        imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one registered output beat with valid/ready handshake and flush.
// Define DECODE_ILLEGAL_CHK_EN to flag unknown opcodes / bad funct7 on illegal_o.
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [ILEN-1:0]   instr_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [3:0]        alu_op_o,
  output logic              alu_src_a_o,
  output logic              alu_src_b_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [REG_W-1:0]  rs1_o,
  output logic [REG_W-1:0]  rs2_o,
  output logic [REG_W-1:0]  rd_o,
  output logic [2:0]        funct3_o,
  output logic              reg_we_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic              branch_o,
  output logic              jump_o,
  output logic              illegal_o
);

  logic [XLEN_W-1:0] imm_w;
  logic              illegal_c;
  logic              accept;
  decode_t           dec_c;
  decode_t           dec_d, dec_q;
  logic              valid_d, valid_q;
  logic [XLEN-1:0]   pc_d, pc_q;

  imm_gen u_imm_gen (
    .instr_i (instr_i),
    .imm_o   (imm_w)
  );

`ifdef DECODE_ILLEGAL_CHK_EN
  // Only 0x00 and 0x20 are legal funct7 values, and 0x20 only on ADD/SUB and SRL/SRA.
  always_comb begin
    illegal_c = 1'b0;
    case (instr_i[6:0])
      OPC_OP:
        illegal_c = !((instr_i[31:25] == 7'h00) ||
                      ((instr_i[31:25] == 7'h20) &&
                       ((instr_i[14:12] == 3'd0) || (instr_i[14:12] == 3'd5))));
      OPC_OPIMM:
        if (instr_i[14:12] == 3'd1) begin
          illegal_c = (instr_i[31:25] != 7'h00);
        end else if (instr_i[14:12] == 3'd5) begin
          illegal_c = (instr_i[31:25] != 7'h00) && (instr_i[31:25] != 7'h20);
        end
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_MISC_MEM, OPC_SYSTEM:
        illegal_c = 1'b0;
      default:
        illegal_c = 1'b1;
    endcase
  end
`else
  assign illegal_c = 1'b0;
`endif

  // Field decode; FENCE, SYSTEM and unknown opcodes fall through as a strobe-free ADD.
  always_comb begin
    dec_c        = '0;
    dec_c.alu_op = ALU_ADD;
    dec_c.imm    = imm_w;
    dec_c.rs1    = instr_i[19:15];
    dec_c.rs2    = instr_i[24:20];
    dec_c.rd     = instr_i[11:7];
    dec_c.funct3 = instr_i[14:12];
    case (instr_i[6:0])
      OPC_OP: begin
        dec_c.alu_op = alu_from_funct3(instr_i[14:12], instr_i[30], 1'b1);
        dec_c.reg_we = 1'b1;
      end
      OPC_OPIMM: begin
        dec_c.alu_op    = alu_from_funct3(instr_i[14:12], instr_i[30], 1'b0);
        dec_c.alu_src_b = 1'b1;
        dec_c.reg_we    = 1'b1;
      end
      OPC_LOAD: begin
        dec_c.alu_src_b = 1'b1;
        dec_c.mem_re    = 1'b1;
        dec_c.reg_we    = 1'b1;
      end
      OPC_STORE: begin
        dec_c.alu_src_b = 1'b1;
        dec_c.mem_we    = 1'b1;
      end
      OPC_JALR: begin
        dec_c.alu_src_b = 1'b1;
        dec_c.jump      = 1'b1;
        dec_c.reg_we    = 1'b1;
      end
      OPC_JAL: begin
        dec_c.alu_src_a = 1'b1;
        dec_c.alu_src_b = 1'b1;
        dec_c.jump      = 1'b1;
        dec_c.reg_we    = 1'b1;
      end
      OPC_AUIPC: begin
        dec_c.alu_src_a = 1'b1;
        dec_c.alu_src_b = 1'b1;
        dec_c.reg_we    = 1'b1;
      end
      OPC_LUI: begin
        dec_c.alu_op    = ALU_PASS_B;
        dec_c.alu_src_b = 1'b1;
        dec_c.reg_we    = 1'b1;
      end
      OPC_BRANCH: begin
        dec_c.branch = 1'b1;
        case (instr_i[14:13])
          2'b10:   dec_c.alu_op = ALU_SLT;
          2'b11:   dec_c.alu_op = ALU_SLTU;
          default: dec_c.alu_op = ALU_SUB;
        endcase
      end
      default: ;
    endcase
    if (instr_i[11:7] == '0) begin
      dec_c.reg_we = 1'b0;
    end
    dec_c.illegal = illegal_c;
    if (illegal_c) begin
      dec_c = kill_strobes(dec_c);
    end
  end

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o;

  // Flush beats accept; a drained or killed beat keeps its data but loses its strobes.
  always_comb begin
    valid_d = valid_q;
    dec_d   = dec_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d       = 1'b0;
      dec_d         = kill_strobes(dec_q);
      dec_d.illegal = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      dec_d   = dec_c;
      pc_d    = pc_i;
    end else if (ready_o) begin
      valid_d       = 1'b0;
      dec_d         = kill_strobes(dec_q);
      dec_d.illegal = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      pc_q    <= RESET_PC;
    end else begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o     = valid_q;
  assign pc_o        = pc_q;
  assign alu_op_o    = dec_q.alu_op;
  assign alu_src_a_o = dec_q.alu_src_a;
  assign alu_src_b_o = dec_q.alu_src_b;
  assign imm_o       = XLEN'(dec_q.imm);
  assign rs1_o       = dec_q.rs1;
  assign rs2_o       = dec_q.rs2;
  assign rd_o        = dec_q.rd;
  assign funct3_o    = dec_q.funct3;
  assign reg_we_o    = dec_q.reg_we;
  assign mem_re_o    = dec_q.mem_re;
  assign mem_we_o    = dec_q.mem_we;
  assign branch_o    = dec_q.branch;
  assign jump_o      = dec_q.jump;
  assign illegal_o   = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed spec vectors plus randomized handshake traffic.
module tb_decode_stage;

  logic        clk, rst;
  logic        valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [31:0] instr_i, pc_i, pc_o, imm_o;
  logic [3:0]  alu_op_o;
  logic        alu_src_a_o, alu_src_b_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [2:0]  funct3_o;
  logic        reg_we_o, mem_re_o, mem_we_o, branch_o, jump_o, illegal_o;

  int checks   = 0;
  int failures = 0;

  decode_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .pc_o(pc_o), .alu_op_o(alu_op_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rd_o(rd_o), .funct3_o(funct3_o), .reg_we_o(reg_we_o), .mem_re_o(mem_re_o),
    .mem_we_o(mem_we_o), .branch_o(branch_o), .jump_o(jump_o), .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected decoded beat; stb = {reg_we, mem_re, mem_we, branch, jump}.
  typedef struct {
    logic [3:0]  alu;
    logic        sa, sb;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [4:0]  stb;
    logic        ill;
  } exp_t;

  exp_t        m;
  logic        m_valid;
  logic [31:0] m_pc;

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t        e;
    logic [3:0]  op_tab [8];
    logic [31:0] iimm, simm, bimm, uimm, jimm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        writes, known, bad_f7;
    op_tab = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
    f3   = ins[14:12];
    f7   = ins[31:25];
    iimm = 32'($signed(ins) >>> 20);
    simm = (iimm & ~32'h1F) | 32'(ins[11:7]);
    bimm = (ins[31] ? 32'hFFFFF000 : 32'h0) | (32'(ins[7]) << 11) |
           (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    uimm = ins & 32'hFFFFF000;
    jimm = (ins[31] ? 32'hFFF00000 : 32'h0) | (32'(ins[19:12]) << 12) |
           (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    e.alu = 4'h0; e.sa = 1'b0; e.sb = 1'b0; e.imm = 32'h0; e.stb = 5'b0; e.ill = 1'b0;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = f3;
    writes = 1'b0; known = 1'b1; bad_f7 = 1'b0;
    case (ins[6:0])
      7'h33: begin
        if (f3 == 3'd0)      e.alu = ins[30] ? 4'h1 : 4'h0;
        else if (f3 == 3'd5) e.alu = ins[30] ? 4'h7 : 4'h6;
        else                 e.alu = op_tab[f3];
        writes = 1'b1;
        bad_f7 = !((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'h13: begin
        e.alu = (f3 == 3'd5 && ins[30]) ? 4'h7 : op_tab[f3];
        e.sb = 1'b1; e.imm = iimm; writes = 1'b1;
        bad_f7 = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                 ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
      end
      7'h03: begin e.sb = 1'b1; e.imm = iimm; e.stb[3] = 1'b1; writes = 1'b1; end
      7'h23: begin e.sb = 1'b1; e.imm = simm; e.stb[2] = 1'b1; end
      7'h67: begin e.sb = 1'b1; e.imm = iimm; e.stb[0] = 1'b1; writes = 1'b1; end
      7'h6F: begin e.sa = 1'b1; e.sb = 1'b1; e.imm = jimm; e.stb[0] = 1'b1; writes = 1'b1; end
      7'h17: begin e.sa = 1'b1; e.sb = 1'b1; e.imm = uimm; writes = 1'b1; end
      7'h37: begin e.alu = 4'hF; e.sb = 1'b1; e.imm = uimm; writes = 1'b1; end
      7'h63: begin
        if (f3 == 3'd4 || f3 == 3'd5)      e.alu = 4'h3;
        else if (f3 == 3'd6 || f3 == 3'd7) e.alu = 4'h4;
        else                               e.alu = 4'h1;
        e.imm = bimm; e.stb[1] = 1'b1;
      end
      7'h0F, 7'h73: e.imm = iimm;
      default: known = 1'b0;
    endcase
    if (writes && ins[11:7] != 5'd0) e.stb[4] = 1'b1;
`ifdef DECODE_ILLEGAL_CHK_EN
    if (!known || bad_f7) begin e.ill = 1'b1; e.stb = 5'b0; end
`else
    if (!known || bad_f7) e.ill = 1'b0;
`endif
    return e;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_pc = 32'h0;
    m.alu = 4'h0; m.sa = 1'b0; m.sb = 1'b0; m.imm = 32'h0;
    m.rs1 = 5'd0; m.rs2 = 5'd0; m.rd = 5'd0; m.f3 = 3'd0; m.stb = 5'b0; m.ill = 1'b0;
  endtask

  // Applies one cycle of inputs at posedge+1, advances the model, returns at next posedge+1.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl, output logic rdy_seen,
                       output logic rdy_exp);
    logic take;
    valid_i = v; instr_i = ins; pc_i = pc; ready_i = rdy; flush_i = fl;
    #1;
    rdy_seen = ready_o;
    rdy_exp  = !m_valid || rdy;
    take     = v && rdy_exp;
    if (fl) begin
      m_valid = 1'b0; m.stb = 5'b0; m.ill = 1'b0;
    end else if (take) begin
      m_valid = 1'b1; m = ref_decode(ins); m_pc = pc;
    end else if (rdy_exp) begin
      m_valid = 1'b0; m.stb = 5'b0; m.ill = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; instr_i = 32'h0; pc_i = 32'h0; ready_i = 1'b0; flush_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++;
    if ({reg_we_o, mem_re_o, mem_we_o, branch_o, jump_o} !== 5'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=00000",
                           {reg_we_o, mem_re_o, mem_we_o, branch_o, jump_o});
    end
    checks++;
    if ({alu_op_o, imm_o, rd_o, rs1_o, rs2_o, funct3_o} !== 54'h0) begin
      failures++; $display("FAIL reset_fields alu=%h imm=%h rd=%0d exp=0", alu_op_o, imm_o, rd_o);
    end
    checks++;
    if (pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_o); end
    checks++;
    if (illegal_o !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal_o); end
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ins [6]  = '{32'h00500093, 32'h402081B3, 32'h40335293,
                              32'h123453B7, 32'hFE20CCE3, 32'h00500013};
    logic [3:0]  alu [6]  = '{4'h0, 4'h1, 4'h7, 4'hF, 4'h3, 4'h0};
    logic        sb  [6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] imm [6]  = '{32'h5, 32'h0, 32'h3, 32'h12345000, 32'hFFFFFFF8, 32'h5};
    logic [31:0] msk [6]  = '{32'hFFFFFFFF, 32'h0, 32'h1F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [4:0]  rs1 [6]  = '{5'd0, 5'd1, 5'd6, 5'd8, 5'd1, 5'd0};
    logic [4:0]  rs2 [6]  = '{5'd5, 5'd2, 5'd3, 5'd3, 5'd2, 5'd5};
    logic [4:0]  rd  [6]  = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd25, 5'd0};
    logic        we  [6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        br  [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        rs, re;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ins[i], 32'h1000 + 32'(i * 4), 1'b1, 1'b0, rs, re);
      checks++;
      if (valid_o !== 1'b1 || pc_o !== 32'h1000 + 32'(i * 4)) begin
        failures++; $display("FAIL dir%0d_valid_pc valid=%b pc=%h", i, valid_o, pc_o);
      end
      checks++;
      if (alu_op_o !== alu[i] || alu_src_b_o !== sb[i] || alu_src_a_o !== 1'b0) begin
        failures++; $display("FAIL dir%0d_alu got=%h/%b/%b exp=%h/0/%b",
                             i, alu_op_o, alu_src_a_o, alu_src_b_o, alu[i], sb[i]);
      end
      checks++;
      if ((imm_o & msk[i]) !== (imm[i] & msk[i])) begin
        failures++; $display("FAIL dir%0d_imm got=%h exp=%h", i, imm_o & msk[i], imm[i] & msk[i]);
      end
      checks++;
      if ({rs1_o, rs2_o, rd_o} !== {rs1[i], rs2[i], rd[i]}) begin
        failures++; $display("FAIL dir%0d_regs got=%0d,%0d,%0d exp=%0d,%0d,%0d",
                             i, rs1_o, rs2_o, rd_o, rs1[i], rs2[i], rd[i]);
      end
      checks++;
      if ({reg_we_o, branch_o, mem_re_o, mem_we_o, jump_o} !== {we[i], br[i], 3'b000}) begin
        failures++; $display("FAIL dir%0d_strobes got=%b exp=%b", i,
                             {reg_we_o, branch_o, mem_re_o, mem_we_o, jump_o}, {we[i], br[i], 3'b000});
      end
    end
  endtask

  task automatic test_backpressure();
    logic rs, re;
    drive(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, rs, re);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h402081B3, 32'h104, 1'b0, 1'b0, rs, re);
      checks++;
      if (ready_o !== 1'b0 || rs !== 1'b0) begin
        failures++; $display("FAIL hold%0d_ready got=%b/%b exp=0", i, ready_o, rs);
      end
      checks++;
      if (valid_o !== 1'b1 || rd_o !== 5'd1 || imm_o !== 32'h5 || pc_o !== 32'h100 || reg_we_o !== 1'b1) begin
        failures++; $display("FAIL hold%0d_stable valid=%b rd=%0d imm=%h pc=%h we=%b",
                             i, valid_o, rd_o, imm_o, pc_o, reg_we_o);
      end
    end
    drive(1'b1, 32'h402081B3, 32'h104, 1'b1, 1'b0, rs, re);
    checks++;
    if (rs !== 1'b1 || valid_o !== 1'b1 || rd_o !== 5'd3 || alu_op_o !== 4'h1 || pc_o !== 32'h104) begin
      failures++; $display("FAIL release_next_beat ready=%b valid=%b rd=%0d alu=%h pc=%h",
                           rs, valid_o, rd_o, alu_op_o, pc_o);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, rs, re);
    checks++;
    if (valid_o !== 1'b0 || reg_we_o !== 1'b0 || rd_o !== 5'd3 || pc_o !== 32'h104) begin
      failures++; $display("FAIL drain valid=%b we=%b rd=%0d pc=%h exp=0/0/3/104",
                           valid_o, reg_we_o, rd_o, pc_o);
    end
  endtask

  task automatic test_flush();
    logic rs, re;
    drive(1'b1, 32'h00500093, 32'h200, 1'b1, 1'b0, rs, re);
    drive(1'b1, 32'h402081B3, 32'h204, 1'b1, 1'b1, rs, re);
    checks++;
    if (rs !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", rs); end
    checks++;
    if (valid_o !== 1'b0 || reg_we_o !== 1'b0) begin
      failures++; $display("FAIL flush_accept valid=%b we=%b exp=0/0", valid_o, reg_we_o);
    end
    drive(1'b1, 32'h0000A103, 32'h300, 1'b1, 1'b0, rs, re);
    drive(1'b1, 32'h00500093, 32'h304, 1'b0, 1'b1, rs, re);
    checks++;
    if (valid_o !== 1'b0 || mem_re_o !== 1'b0) begin
      failures++; $display("FAIL flush_held valid=%b mem_re=%b exp=0/0", valid_o, mem_re_o);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic rs, re;
    drive(1'b1, 32'h00500093, 32'h400, 1'b1, 1'b0, rs, re);
    drive(1'b1, 32'h402081B3, 32'h404, 1'b0, 1'b0, rs, re);
    rst = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0 || reg_we_o !== 1'b0 || rd_o !== 5'd0 || pc_o !== 32'h0) begin
      failures++; $display("FAIL async_reset valid=%b we=%b rd=%0d pc=%h exp=0", valid_o, reg_we_o, rd_o, pc_o);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_illegal();
    logic rs, re;
    logic exp_ill;
`ifdef DECODE_ILLEGAL_CHK_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    drive(1'b1, 32'hFFFFFFFF, 32'h500, 1'b1, 1'b0, rs, re);
    checks++;
    if (valid_o !== 1'b1 || illegal_o !== exp_ill || alu_op_o !== 4'h0 ||
        {reg_we_o, mem_re_o, mem_we_o, branch_o, jump_o} !== 5'b0) begin
      failures++; $display("FAIL illegal_opcode valid=%b ill=%b alu=%h exp ill=%b", valid_o, illegal_o,
                           alu_op_o, exp_ill);
    end
    drive(1'b1, 32'h02208133, 32'h504, 1'b1, 1'b0, rs, re);
    checks++;
    if (valid_o !== 1'b1 || illegal_o !== exp_ill || reg_we_o !== !exp_ill) begin
      failures++; $display("FAIL illegal_funct7 valid=%b ill=%b we=%b exp ill=%b", valid_o, illegal_o,
                           reg_we_o, exp_ill);
    end
  endtask

  task automatic test_random();
    logic [6:0]  opcs [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h6F,
                               7'h17, 7'h37, 7'h63, 7'h0F, 7'h73};
    logic [31:0] ins;
    logic        rs, re;
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) begin
        ins[6:0] = opcs[$urandom_range(0, 10)];
        if ($urandom_range(0, 7) != 0 && (ins[6:0] == 7'h33 || ins[6:0] == 7'h13)) begin
          ins[31:25] = ((ins[14:12] == 3'd5 || (ins[14:12] == 3'd0 && ins[6:0] == 7'h33)) &&
                        $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
      end
      drive($urandom_range(0, 9) < 7, ins, $urandom & 32'hFFFFFFFC,
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, rs, re);
      checks++;
      if (rs !== re) begin failures++; $display("FAIL rnd%0d_ready got=%b exp=%b", n, rs, re); end
      checks++;
      if (valid_o !== m_valid || pc_o !== m_pc) begin
        failures++; $display("FAIL rnd%0d_valid_pc got=%b/%h exp=%b/%h", n, valid_o, pc_o, m_valid, m_pc);
      end
      checks++;
      if ({alu_op_o, alu_src_a_o, alu_src_b_o, funct3_o} !== {m.alu, m.sa, m.sb, m.f3}) begin
        failures++; $display("FAIL rnd%0d_alu ins=%h got=%h/%b/%b/%0d exp=%h/%b/%b/%0d", n, ins, alu_op_o,
                             alu_src_a_o, alu_src_b_o, funct3_o, m.alu, m.sa, m.sb, m.f3);
      end
      checks++;
      if (imm_o !== m.imm) begin failures++; $display("FAIL rnd%0d_imm got=%h exp=%h", n, imm_o, m.imm); end
      checks++;
      if ({rs1_o, rs2_o, rd_o} !== {m.rs1, m.rs2, m.rd}) begin
        failures++; $display("FAIL rnd%0d_regs got=%0d,%0d,%0d exp=%0d,%0d,%0d",
                             n, rs1_o, rs2_o, rd_o, m.rs1, m.rs2, m.rd);
      end
      checks++;
      if ({reg_we_o, mem_re_o, mem_we_o, branch_o, jump_o, illegal_o} !== {m.stb, m.ill}) begin
        failures++; $display("FAIL rnd%0d_strobes got=%b exp=%b", n,
                             {reg_we_o, mem_re_o, mem_we_o, branch_o, jump_o, illegal_o}, {m.stb, m.ill});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid_hold();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
